// File: rtl/serpent_axi_rd_reorder.sv
// serpent_axi_rd_reorder
//  Read-ordering buffer between serpent_l15_adapter read requests and the AXI
//  read channel. Up to NumTx reads are outstanding, each tagged with its slot
//  index as AXI ID. Responses may return in any order. They are handed back
//  upstream strictly in request order, carrying the original requester ID.
//  Optional feature macro: SERPENT_RDREORDER_BYPASS_EN. It forwards a response
//  for the head slot combinationally in the same cycle it arrives.
module serpent_axi_rd_reorder #(
  parameter int unsigned NumTx     = 4,
  parameter int unsigned IdWidth   = 10,
  parameter int unsigned DataWidth = 512
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_i,
  input  logic [IdWidth-1:0]         req_id_i,
  output logic                       gnt_o,
  output logic                       mem_req_o,
  output logic [$clog2(NumTx)-1:0]   mem_id_o,
  input  logic                       mem_gnt_i,
  input  logic                       mem_rvalid_i,
  input  logic [$clog2(NumTx)-1:0]   mem_rid_i,
  input  logic [DataWidth-1:0]       mem_rdata_i,
  output logic                       mem_rrdy_o,
  output logic                       rtrn_valid_o,
  output logic [IdWidth-1:0]         rtrn_id_o,
  output logic [DataWidth-1:0]       rtrn_data_o,
  input  logic                       rtrn_rdy_i,
  output logic                       err_o
);

  localparam int unsigned SlotW = $clog2(NumTx);

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_PEND,
    SLOT_DONE
  } slot_state_e;

  slot_state_e          slot_q [NumTx];
  slot_state_e          slot_d [NumTx];
  logic [IdWidth-1:0]   id_q   [NumTx];
  logic [DataWidth-1:0] data_q [NumTx];

  logic [SlotW-1:0] head_q, tail_q;
  logic [SlotW:0]   cnt_q, cnt_d;
  logic             full, alloc, rel, rsp_ok, head_done, err_q;
`ifdef SERPENT_RDREORDER_BYPASS_EN
  logic             bypass;
`endif

  // Response qualification: only a response for a pending slot is accepted
  always_comb begin
    rsp_ok = mem_rvalid_i & (slot_q[mem_rid_i] == SLOT_PEND);
  end

  // Output decode: request side, return side and handshake events
  always_comb begin
    full       = (cnt_q == (SlotW+1)'(NumTx));
    // rst_ni gating keeps the request outputs at their reset values even if
    // req_i is high while reset is asserted.
    mem_req_o  = req_i & ~full & rst_ni;
    mem_id_o   = tail_q;
    gnt_o      = mem_req_o & mem_gnt_i;
    alloc      = gnt_o;
    mem_rrdy_o = 1'b1;
    err_o      = err_q;
    head_done  = (slot_q[head_q] == SLOT_DONE);
    rtrn_id_o  = id_q[head_q];
`ifdef SERPENT_RDREORDER_BYPASS_EN
    bypass       = rsp_ok & (mem_rid_i == head_q);
    rtrn_valid_o = head_done | bypass;
    rtrn_data_o  = bypass ? mem_rdata_i : data_q[head_q];
`else
    rtrn_valid_o = head_done;
    rtrn_data_o  = data_q[head_q];
`endif
    rel = rtrn_valid_o & rtrn_rdy_i;
  end

  // Slot next-state: alloc marks tail PEND, response marks DONE, release frees head
  always_comb begin
    for (int unsigned i = 0; i < NumTx; i++) begin
      slot_d[i] = slot_q[i];
    end
    if (alloc)  slot_d[tail_q]    = SLOT_PEND;
    if (rsp_ok) slot_d[mem_rid_i] = SLOT_DONE;
    // A bypassed head response that is consumed at once goes PEND->FREE,
    // because the release assignment overrides the DONE above.
    if (rel)    slot_d[head_q]    = SLOT_FREE;
  end

  // Slot state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumTx; i++) begin
        slot_q[i] <= SLOT_FREE;
      end
    end else begin
      for (int unsigned i = 0; i < NumTx; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  // Occupancy next value: simultaneous alloc and release cancel out
  always_comb begin
    cnt_d = cnt_q;
    if (alloc && !rel) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!alloc && rel) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Ring pointers, occupancy and sticky error flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (alloc) tail_q <= tail_q + 1'b1;
      if (rel)   head_q <= head_q + 1'b1;
      if (mem_rvalid_i && !rsp_ok) err_q <= 1'b1;
    end
  end

  // Per-slot requester ID captured on allocation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumTx; i++) begin
        id_q[i] <= '0;
      end
    end else if (alloc) begin
      id_q[tail_q] <= req_id_i;
    end
  end

  // Per-slot response data captured on an accepted response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumTx; i++) begin
        data_q[i] <= '0;
      end
    end else if (rsp_ok) begin
      data_q[mem_rid_i] <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_serpent_axi_rd_reorder.sv
// tb_serpent_axi_rd_reorder
//  Directed self-checking bench for serpent_axi_rd_reorder (NumTx=4).
//  Inputs change 1 ns after a rising edge, and outputs are checked 1 ns later.
module tb_serpent_axi_rd_reorder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic [9:0]   req_id;
  logic         gnt;
  logic         mem_req;
  logic [1:0]   mem_id;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [1:0]   mem_rid;
  logic [511:0] mem_rdata;
  logic         mem_rrdy;
  logic         rtrn_valid;
  logic [9:0]   rtrn_id;
  logic [511:0] rtrn_data;
  logic         rtrn_rdy;
  logic         err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  serpent_axi_rd_reorder #(
    .NumTx    (4),
    .IdWidth  (10),
    .DataWidth(512)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .req_id_i    (req_id),
    .gnt_o       (gnt),
    .mem_req_o   (mem_req),
    .mem_id_o    (mem_id),
    .mem_gnt_i   (mem_gnt),
    .mem_rvalid_i(mem_rvalid),
    .mem_rid_i   (mem_rid),
    .mem_rdata_i (mem_rdata),
    .mem_rrdy_o  (mem_rrdy),
    .rtrn_valid_o(rtrn_valid),
    .rtrn_id_o   (rtrn_id),
    .rtrn_data_o (rtrn_data),
    .rtrn_rdy_i  (rtrn_rdy),
    .err_o       (err)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mkdata(input logic [7:0] k);
    return {64{k}} ^ {16{32'h0123_4567}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req        = 1'b0;
    req_id     = '0;
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b0;
    mem_rid    = '0;
    mem_rdata  = '0;
    rtrn_rdy   = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Issue one granted request; checks the slot it is assigned
  task automatic issue(input logic [9:0] id, input logic [1:0] exp_slot, input string tag);
    req    = 1'b1;
    req_id = id;
    #1;
    check({tag, "_gnt"}, gnt, 1'b1);
    check({tag, "_mem_id"}, mem_id, exp_slot);
    tick();
    req = 1'b0;
  endtask

  task automatic respond(input logic [1:0] rid, input logic [511:0] d);
    mem_rvalid = 1'b1;
    mem_rid    = rid;
    mem_rdata  = d;
    tick();
    mem_rvalid = 1'b0;
  endtask

  logic [9:0] exp_ids [4];

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    // ---------------- reset state
    tick();
    check("rst_gnt", gnt, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_id", mem_id, 2'd0);
    check("rst_rrdy", mem_rrdy, 1'b1);
    check("rst_rvalid", rtrn_valid, 1'b0);
    check("rst_rid", rtrn_id, 10'd0);
    check("rst_rdata", rtrn_data, 512'd0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;
    tick();

    // ---------------- 1: single read, plus a request the adapter refuses
    req = 1'b1; req_id = 10'h155; mem_gnt = 1'b0;
    #1;
    check("t1_nognt_memreq", mem_req, 1'b1);
    check("t1_nognt_gnt", gnt, 1'b0);
    tick();
    mem_gnt = 1'b1;
    issue(10'h155, 2'd0, "t1_req");
    mem_rvalid = 1'b1; mem_rid = 2'd0; mem_rdata = mkdata(8'hD0);
    #1;
`ifdef SERPENT_RDREORDER_BYPASS_EN
    check("t1_same_cycle_valid", rtrn_valid, 1'b1);
    check("t1_same_cycle_data", rtrn_data, mkdata(8'hD0));
`else
    check("t1_same_cycle_valid", rtrn_valid, 1'b0);
`endif
    tick();
    mem_rvalid = 1'b0;
    #1;
    check("t1_valid", rtrn_valid, 1'b1);
    check("t1_id", rtrn_id, 10'h155);
    check("t1_data", rtrn_data, mkdata(8'hD0));
    rtrn_rdy = 1'b1;
    tick();
    rtrn_rdy = 1'b0;
    #1;
    check("t1_released", rtrn_valid, 1'b0);

    // ---------------- 2: reorder, responses 3,1,0,2
    do_reset();
    issue(10'h1, 2'd0, "t2_req0");
    issue(10'h2, 2'd1, "t2_req1");
    issue(10'h3, 2'd2, "t2_req2");
    issue(10'h4, 2'd3, "t2_req3");
    respond(2'd3, mkdata(8'h13));
    check("t2_wait_after_r3", rtrn_valid, 1'b0);
    respond(2'd1, mkdata(8'h11));
    check("t2_wait_after_r1", rtrn_valid, 1'b0);
    respond(2'd0, mkdata(8'h10));
    check("t2_valid_after_r0", rtrn_valid, 1'b1);
    check("t2_head_id", rtrn_id, 10'h1);
    respond(2'd2, mkdata(8'h12));
    rtrn_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t2_valid%0d", k), rtrn_valid, 1'b1);
      check($sformatf("t2_id%0d", k), rtrn_id, 10'(k + 1));
      check($sformatf("t2_data%0d", k), rtrn_data, mkdata(8'(8'h10 + k)));
      @(posedge clk);
    end
    #1;
    rtrn_rdy = 1'b0;
    #1;
    check("t2_drained", rtrn_valid, 1'b0);
    tick();

    // ---------------- 3: full, then wrap to slot 0 after one release
    issue(10'h11, 2'd0, "t3_req0");
    issue(10'h12, 2'd1, "t3_req1");
    issue(10'h13, 2'd2, "t3_req2");
    issue(10'h14, 2'd3, "t3_req3");
    req = 1'b1; req_id = 10'h15;
    #1;
    check("t3_full_gnt", gnt, 1'b0);
    check("t3_full_memreq", mem_req, 1'b0);
    respond(2'd0, mkdata(8'h20));
    rtrn_rdy = 1'b1;
    #1;
    check("t3_release_valid", rtrn_valid, 1'b1);
    check("t3_no_same_cycle_reuse", gnt, 1'b0);
    tick();
    rtrn_rdy = 1'b0;
    #1;
    check("t3_after_release_gnt", gnt, 1'b1);
    check("t3_wrap_mem_id", mem_id, 2'd0);
    tick();
    req = 1'b0;

    // ---------------- 4: backpressure on slot 1, then alloc+release together
    respond(2'd1, mkdata(8'h21));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_hold_valid%0d", k), rtrn_valid, 1'b1);
      check($sformatf("t4_hold_id%0d", k), rtrn_id, 10'h12);
      check($sformatf("t4_hold_data%0d", k), rtrn_data, mkdata(8'h21));
      tick();
    end
    rtrn_rdy = 1'b1;
    tick();
    rtrn_rdy = 1'b0;
    respond(2'd2, mkdata(8'h22));
    req = 1'b1; req_id = 10'h16; rtrn_rdy = 1'b1;
    #1;
    check("t4_both_gnt", gnt, 1'b1);
    check("t4_both_valid", rtrn_valid, 1'b1);
    check("t4_both_id", rtrn_id, 10'h13);
    check("t4_both_mem_id", mem_id, 2'd1);
    tick();
    rtrn_rdy = 1'b0;
    issue(10'h17, 2'd2, "t4_cnt_kept");
    req = 1'b1; req_id = 10'h18;
    #1;
    check("t4_full_again", gnt, 1'b0);
    tick();
    req = 1'b0;

    // ---------------- 5: response for a free slot
    do_reset();
    check("t5_err_cleared", err, 1'b0);
    issue(10'h31, 2'd0, "t5_req0");
    issue(10'h32, 2'd1, "t5_req1");
    respond(2'd2, mkdata(8'hEE));
    check("t5_err_set", err, 1'b1);
    check("t5_no_valid", rtrn_valid, 1'b0);
    respond(2'd0, mkdata(8'h41));
    check("t5_id0", rtrn_id, 10'h31);
    check("t5_data0", rtrn_data, mkdata(8'h41));
    rtrn_rdy = 1'b1;
    tick();
    rtrn_rdy = 1'b0;
    respond(2'd1, mkdata(8'h42));
    check("t5_valid1", rtrn_valid, 1'b1);
    check("t5_id1", rtrn_id, 10'h32);
    check("t5_err_sticky", err, 1'b1);
    rtrn_rdy = 1'b1;
    tick();
    rtrn_rdy = 1'b0;
    #1;
    check("t5_dropped_not_stored", rtrn_valid, 1'b0);

    // ---------------- 6: reset in the middle of traffic
    tick();
    issue(10'h51, 2'd2, "t6_req0");
    issue(10'h52, 2'd3, "t6_req1");
    issue(10'h53, 2'd0, "t6_req2");
    respond(2'd2, mkdata(8'h61));
    check("t6_pre_valid", rtrn_valid, 1'b1);
    req = 1'b1; req_id = 10'h60;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_gnt", gnt, 1'b0);
    check("t6_mem_req", mem_req, 1'b0);
    check("t6_mem_id", mem_id, 2'd0);
    check("t6_rrdy", mem_rrdy, 1'b1);
    check("t6_valid", rtrn_valid, 1'b0);
    check("t6_rid", rtrn_id, 10'd0);
    check("t6_rdata", rtrn_data, 512'd0);
    check("t6_err", err, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_post_gnt", gnt, 1'b1);
    check("t6_post_mem_id", mem_id, 2'd0);
    tick();
    req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
